multicycle_control: RTL and testbench

Moore-style control unit that sequences a multicycle RV32I datapath: a shared memory, an instruction register, a register file and one ALU, reused across several cycles per instruction. It replaces the single-cycle core's combinational decoder and sits beside the datapath inside the top level. Each cycle it drives all mux selects, write enables and the ALU operation from its state and the decoded instruction fields. Supported instructions: lw, sw, R-type (add/sub/and/or/slt), I-type ALU (addi/andi/ori/slti), beq, jal.

---
 rtl/multicycle_control.sv | 247 ++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// multicycle_control: Moore control FSM for a multicycle RV32I datapath
// (lw, sw, R-type, I-type ALU, beq, jal). Drives every mux select, write
// enable and the ALU operation from the current state and the IR fields.
// Optional feature: define MCCTRL_BNE_EN to execute funct3=001 in BEQ as bne.
module multicycle_control (
  input  logic       CLK,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  state_t     state_r;
  state_t     next_s;
  state_t     out_state_s;
  logic       pc_update_s;
  logic       branch_s;
  logic       taken_s;
  logic       mem_write_s;
  logic       ir_write_s;
  logic       reg_write_s;
  logic       op_legal_s;
  logic [1:0] aluop_s;

  // Opcode legality, used for both the DECODE dispatch and the illegal pulse
  always_comb begin
    case (op)
      OP_LW, OP_SW, OP_RTYPE, OP_ITYPE, OP_JAL, OP_BEQ: op_legal_s = 1'b1;
      default:                                          op_legal_s = 1'b0;
    endcase
  end

  // Next-state logic; unreachable codes fall back to FETCH
  always_comb begin
    next_s = S_FETCH;
    case (state_r)
      S_FETCH:    next_s = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: next_s = S_MEMADR;
          OP_RTYPE:     next_s = S_EXECUTER;
          OP_ITYPE:     next_s = S_EXECUTEI;
          OP_JAL:       next_s = S_JAL;
          OP_BEQ:       next_s = S_BEQ;
          default:      next_s = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (op == OP_LW) begin
          next_s = S_MEMREAD;
        end else begin
          next_s = S_MEMWRITE;
        end
      end
      S_MEMREAD:  next_s = S_MEMWB;
      S_EXECUTER: next_s = S_ALUWB;
      S_EXECUTEI: next_s = S_ALUWB;
      S_JAL:      next_s = S_ALUWB;
      S_MEMWB:    next_s = S_FETCH;
      S_MEMWRITE: next_s = S_FETCH;
      S_ALUWB:    next_s = S_FETCH;
      S_BEQ:      next_s = S_FETCH;
      default:    next_s = S_FETCH;
    endcase
  end

  // State register; reset abandons any partial instruction
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_s;
    end
  end

  // While in reset the outputs present the FETCH decode
  always_comb begin
    if (rst) begin
      out_state_s = S_FETCH;
    end else begin
      out_state_s = state_r;
    end
  end

  assign state = out_state_s;

  // Moore decode of the per-state control values
  always_comb begin
    pc_update_s = 1'b0;
    branch_s    = 1'b0;
    aluop_s     = 2'b00;
    AdrSrc      = 1'b0;
    mem_write_s = 1'b0;
    ir_write_s  = 1'b0;
    reg_write_s = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    case (out_state_s)
      S_FETCH: begin
        ir_write_s  = 1'b1;
        ALUSrcB     = 2'b10;
        ResultSrc   = 2'b10;
        pc_update_s = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc   = 2'b01;
        reg_write_s = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc      = 1'b1;
        mem_write_s = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA = 2'b10;
        aluop_s = 2'b10;
      end
      S_EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        aluop_s = 2'b10;
      end
      S_ALUWB: reg_write_s = 1'b1;
      S_JAL: begin
        ALUSrcA     = 2'b01;
        ALUSrcB     = 2'b10;
        pc_update_s = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA  = 2'b10;
        aluop_s  = 2'b01;
        branch_s = 1'b1;
      end
      default: begin
        pc_update_s = 1'b0;
      end
    endcase
  end

  // Branch decision; Zero only matters while branch_s is set (BEQ state)
  always_comb begin
`ifdef MCCTRL_BNE_EN
    case (funct3)
      3'b000:  taken_s = branch_s & Zero;
      3'b001:  taken_s = branch_s & ~Zero;
      default: taken_s = 1'b0;
    endcase
`else
    taken_s = branch_s & Zero;
`endif
  end

  // Write enables and the illegal pulse are suppressed during reset
  always_comb begin
    if (rst) begin
      PCWrite  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      illegal  = 1'b0;
    end else begin
      PCWrite  = pc_update_s | taken_s;
      MemWrite = mem_write_s;
      IRWrite  = ir_write_s;
      RegWrite = reg_write_s;
      illegal  = (state_r == S_DECODE) & ~op_legal_s;
    end
  end

  // Immediate format follows the opcode in every state
  always_comb begin
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // ALU decoder; sub for R-type only (op[5] separates R from I encodings)
  always_comb begin
    case (aluop_s)
      2'b00: ALUControl = 3'b000;
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000: begin
            if (op[5] & funct7b5) begin
              ALUControl = 3'b001;
            end else begin
              ALUControl = 3'b000;
            end
          end
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Table-driven bench for multicycle_control: per-cycle vectors with expected
// outputs go through a scoreboard queue; latency sequences are hand-written.
module tb_multicycle_control;

  logic       CLK = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op = 7'b0000011;
  logic [2:0] funct3 = 3'b000;
  logic       funct7b5 = 1'b0;
  logic       Zero = 1'b0;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] state;

  multicycle_control dut (
    .CLK(CLK), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .illegal(illegal), .state(state)
  );

  always #5 CLK = ~CLK;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] ILL = 7'b1110011;
`ifdef MCCTRL_BNE_EN
  localparam logic BNE = 1'b1;
`else
  localparam logic BNE = 1'b0;
`endif

  // expected word: {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,
  //                 ALUSrcA,ALUSrcB,ImmSrc,ALUControl,illegal,state}
  typedef struct {
    string       tag;
    logic        r;
    logic [6:0]  o;
    logic [2:0]  f3;
    logic        f7;
    logic        z;
    logic [20:0] exp;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic add(input string tag, input logic r, input logic [6:0] o,
                     input logic [2:0] f3, input logic f7, input logic z,
                     input logic [3:0] st, input logic [4:0] en,
                     input logic [1:0] rs, input logic [1:0] sa,
                     input logic [1:0] sbv, input logic [1:0] im,
                     input logic [2:0] alu, input logic ill);
    vec_t v;
    v.tag = tag; v.r = r; v.o = o; v.f3 = f3; v.f7 = f7; v.z = z;
    v.exp = {en, rs, sa, sbv, im, alu, ill, st};
    tbl.push_back(v);
  endtask

  task automatic measure(input string tag, input logic [6:0] o, input int exp_lat);
    int cnt;
    bit done;
    @(negedge CLK);
    rst = 1'b1; op = o; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b0;
    @(negedge CLK);
    rst = 1'b0;
    cnt = 0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge CLK);
      cnt++;
      if (state == 4'd0) done = 1'b1;
    end
    n_vec++;
    if (!done || cnt != exp_lat) begin
      n_bad++;
      $display("FAIL latency_%s: got %0d cycles (returned=%0d), expected %0d", tag, cnt, done, exp_lat);
    end
  endtask

  initial begin
    logic [20:0] got;
    vec_t e;
    //        tag        r  op   f3      f7    z     st     en        rs     sa     sb     imm    alu     ill
    add("reset",     1, LW,  3'b000, 1'b0, 1'b0, 4'd0,  5'b00000, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 1'b0);
    add("lw_fetch",  0, LW,  3'b010, 1'b0, 1'b1, 4'd0,  5'b10010, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 1'b0);
    add("lw_decode", 0, LW,  3'b010, 1'b0, 1'b1, 4'd1,  5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 1'b0);
    add("lw_memadr", 0, LW,  3'b010, 1'b0, 1'b1, 4'd2,  5'b00000, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 1'b0);
    add("lw_memrd",  0, LW,  3'b010, 1'b0, 1'b1, 4'd3,  5'b01000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0);
    add("lw_memwb",  0, LW,  3'b010, 1'b0, 1'b1, 4'd4,  5'b00001, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0);
    add("sw_fetch",  0, SW,  3'b010, 1'b0, 1'b0, 4'd0,  5'b10010, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000, 1'b0);
    add("sw_decode", 0, SW,  3'b010, 1'b0, 1'b0, 4'd1,  5'b00000, 2'b00, 2'b01, 2'b01, 2'b01, 3'b000, 1'b0);
    add("sw_memadr", 0, SW,  3'b010, 1'b0, 1'b0, 4'd2,  5'b00000, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 1'b0);
    add("sw_memwr",  0, SW,  3'b010, 1'b0, 1'b0, 4'd5,  5'b01100, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 1'b0);
    add("sub_fetch", 0, RT,  3'b000, 1'b1, 1'b0, 4'd0,  5'b10010, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 1'b0);
    add("sub_dec",   0, RT,  3'b000, 1'b1, 1'b0, 4'd1,  5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 1'b0);
    add("sub_exec",  0, RT,  3'b000, 1'b1, 1'b0, 4'd6,  5'b00000, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001, 1'b0);
    add("sub_wb",    0, RT,  3'b000, 1'b1, 1'b0, 4'd7,  5'b00001, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0);
    add("slt_fetch", 0, RT,  3'b010, 1'b0, 1'b0, 4'd0,  5'b10010, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 1'b0);
    add("slt_dec",   0, RT,  3'b010, 1'b0, 1'b0, 4'd1,  5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 1'b0);
    add("slt_exec",  0, RT,  3'b010, 1'b0, 1'b0, 4'd6,  5'b00000, 2'b00, 2'b10, 2'b00, 2'b00, 3'b101, 1'b0);
    add("slt_wb",    0, RT,  3'b010, 1'b0, 1'b0, 4'd7,  5'b00001, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0);
    add("and_fetch", 0, RT,  3'b111, 1'b0, 1'b0, 4'd0,  5'b10010, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 1'b0);
    add("and_dec",   0, RT,  3'b111, 1'b0, 1'b0, 4'd1,  5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 1'b0);
    add("and_exec",  0, RT,  3'b111, 1'b0, 1'b0, 4'd6,  5'b00000, 2'b00, 2'b10, 2'b00, 2'b00, 3'b010, 1'b0);
    add("and_wb",    0, RT,  3'b111, 1'b0, 1'b0, 4'd7,  5'b00001, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0);
    add("ori_fetch", 0, IT,  3'b110, 1'b0, 1'b0, 4'd0,  5'b10010, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 1'b0);
    add("ori_dec",   0, IT,  3'b110, 1'b0, 1'b0, 4'd1,  5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 1'b0);
    add("ori_exec",  0, IT,  3'b110, 1'b0, 1'b0, 4'd8,  5'b00000, 2'b00, 2'b10, 2'b01, 2'b00, 3'b011, 1'b0);
    add("ori_wb",    0, IT,  3'b110, 1'b0, 1'b0, 4'd7,  5'b00001, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0);
    add("addi_fetch",0, IT,  3'b000, 1'b1, 1'b0, 4'd0,  5'b10010, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 1'b0);
    add("addi_dec",  0, IT,  3'b000, 1'b1, 1'b0, 4'd1,  5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 1'b0);
    add("addi_exec", 0, IT,  3'b000, 1'b1, 1'b0, 4'd8,  5'b00000, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 1'b0);
    add("addi_wb",   0, IT,  3'b000, 1'b1, 1'b0, 4'd7,  5'b00001, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0);
    add("xor_fetch", 0, RT,  3'b100, 1'b1, 1'b0, 4'd0,  5'b10010, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 1'b0);
    add("xor_dec",   0, RT,  3'b100, 1'b1, 1'b0, 4'd1,  5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 1'b0);
    add("xor_exec",  0, RT,  3'b100, 1'b1, 1'b0, 4'd6,  5'b00000, 2'b00, 2'b10, 2'b00, 2'b00, 3'b000, 1'b0);
    add("xor_wb",    0, RT,  3'b100, 1'b1, 1'b0, 4'd7,  5'b00001, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0);
    add("beq1_fetch",0, BQ,  3'b000, 1'b0, 1'b1, 4'd0,  5'b10010, 2'b10, 2'b00, 2'b10, 2'b10, 3'b000, 1'b0);
    add("beq1_dec",  0, BQ,  3'b000, 1'b0, 1'b1, 4'd1,  5'b00000, 2'b00, 2'b01, 2'b01, 2'b10, 3'b000, 1'b0);
    add("beq1_br",   0, BQ,  3'b000, 1'b0, 1'b1, 4'd10, 5'b10000, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 1'b0);
    add("beq0_fetch",0, BQ,  3'b000, 1'b0, 1'b0, 4'd0,  5'b10010, 2'b10, 2'b00, 2'b10, 2'b10, 3'b000, 1'b0);
    add("beq0_dec",  0, BQ,  3'b000, 1'b0, 1'b0, 4'd1,  5'b00000, 2'b00, 2'b01, 2'b01, 2'b10, 3'b000, 1'b0);
    add("beq0_br",   0, BQ,  3'b000, 1'b0, 1'b0, 4'd10, 5'b00000, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 1'b0);
    add("bne0_fetch",0, BQ,  3'b001, 1'b0, 1'b0, 4'd0,  5'b10010, 2'b10, 2'b00, 2'b10, 2'b10, 3'b000, 1'b0);
    add("bne0_dec",  0, BQ,  3'b001, 1'b0, 1'b0, 4'd1,  5'b00000, 2'b00, 2'b01, 2'b01, 2'b10, 3'b000, 1'b0);
    add("bne0_br",   0, BQ,  3'b001, 1'b0, 1'b0, 4'd10, {BNE, 4'b0000}, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 1'b0);
    add("bne1_fetch",0, BQ,  3'b001, 1'b0, 1'b1, 4'd0,  5'b10010, 2'b10, 2'b00, 2'b10, 2'b10, 3'b000, 1'b0);
    add("bne1_dec",  0, BQ,  3'b001, 1'b0, 1'b1, 4'd1,  5'b00000, 2'b00, 2'b01, 2'b01, 2'b10, 3'b000, 1'b0);
    add("bne1_br",   0, BQ,  3'b001, 1'b0, 1'b1, 4'd10, {~BNE, 4'b0000}, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 1'b0);
    add("b010_fetch",0, BQ,  3'b010, 1'b0, 1'b1, 4'd0,  5'b10010, 2'b10, 2'b00, 2'b10, 2'b10, 3'b000, 1'b0);
    add("b010_dec",  0, BQ,  3'b010, 1'b0, 1'b1, 4'd1,  5'b00000, 2'b00, 2'b01, 2'b01, 2'b10, 3'b000, 1'b0);
    add("b010_br",   0, BQ,  3'b010, 1'b0, 1'b1, 4'd10, {~BNE, 4'b0000}, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 1'b0);
    add("jal_fetch", 0, JL,  3'b000, 1'b0, 1'b0, 4'd0,  5'b10010, 2'b10, 2'b00, 2'b10, 2'b11, 3'b000, 1'b0);
    add("jal_dec",   0, JL,  3'b000, 1'b0, 1'b0, 4'd1,  5'b00000, 2'b00, 2'b01, 2'b01, 2'b11, 3'b000, 1'b0);
    add("jal_jal",   0, JL,  3'b000, 1'b0, 1'b0, 4'd9,  5'b10000, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000, 1'b0);
    add("jal_wb",    0, JL,  3'b000, 1'b0, 1'b0, 4'd7,  5'b00001, 2'b00, 2'b00, 2'b00, 2'b11, 3'b000, 1'b0);
    add("ill_fetch", 0, ILL, 3'b000, 1'b0, 1'b0, 4'd0,  5'b10010, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 1'b0);
    add("ill_dec",   0, ILL, 3'b000, 1'b0, 1'b0, 4'd1,  5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 1'b1);
    add("ill_after", 0, ILL, 3'b000, 1'b0, 1'b0, 4'd0,  5'b10010, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 1'b0);
    add("ill_dec_rs",1, ILL, 3'b000, 1'b0, 1'b0, 4'd0,  5'b00000, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 1'b0);
    add("mr_fetch",  0, LW,  3'b010, 1'b0, 1'b0, 4'd0,  5'b10010, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 1'b0);
    add("mr_decode", 0, LW,  3'b010, 1'b0, 1'b0, 4'd1,  5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 1'b0);
    add("mr_memadr", 0, LW,  3'b010, 1'b0, 1'b0, 4'd2,  5'b00000, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 1'b0);
    add("mr_reset",  1, LW,  3'b010, 1'b0, 1'b0, 4'd0,  5'b00000, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 1'b0);
    add("mr_refetch",0, LW,  3'b010, 1'b0, 1'b0, 4'd0,  5'b10010, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 1'b0);
    add("mr_redec",  0, LW,  3'b010, 1'b0, 1'b0, 4'd1,  5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge CLK);
      rst = tbl[i].r; op = tbl[i].o; funct3 = tbl[i].f3;
      funct7b5 = tbl[i].f7; Zero = tbl[i].z;
      sb.push_back(tbl[i]);
      #2;
      e = sb.pop_front();
      got = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
             ALUSrcB, ImmSrc, ALUControl, illegal, state};
      n_vec++;
      if (got !== e.exp) begin
        n_bad++;
        $display("FAIL %s: got %b expected %b (pcw,adr,mw,irw,rw,rs,sa,sb,imm,alu,ill,st)",
                 e.tag, got, e.exp);
      end
    end

    measure("lw",  LW,  5);
    measure("sw",  SW,  4);
    measure("rt",  RT,  4);
    measure("it",  IT,  4);
    measure("jal", JL,  4);
    measure("beq", BQ,  3);
    measure("ill", ILL, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
